// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: channel indices, FSM state
// encoding, default timing values and small constant helpers.
package btn_pkg;

    // Channel indices into btn_raw / level / press / act
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_THROW = 2;
    localparam int BTN_START = 3;
    localparam int NUM_BTN   = 4;

    // Default timing: 1 kHz sample tick from a 50 MHz clock
    localparam int DEF_SAMPLE_DIV = 50000;
    localparam int DEF_DEBOUNCE_N = 8;
    localparam int DEF_REP_DELAY  = 400;
    localparam int DEF_REP_PERIOD = 100;
    localparam logic [NUM_BTN-1:0] DEF_REP_MASK = 4'b0011;

    // Per-channel FSM state encoding
    localparam logic [2:0] ST_IDLE            = 3'd0;
    localparam logic [2:0] ST_CONFIRM_PRESS   = 3'd1;
    localparam logic [2:0] ST_DELAY           = 3'd2;
    localparam logic [2:0] ST_REPEAT          = 3'd3;
    localparam logic [2:0] ST_CONFIRM_RELEASE = 3'd4;

    // Counter width able to hold the value n itself
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce / auto-repeat FSM and
// its counters. The FSM only moves on the shared sample tick; level, press
// and act are registered so they change on the clock edge ending the tick.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_N = DEF_DEBOUNCE_N,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD,
    parameter bit REP_EN     = 1'b0
) (
    input  logic CLK,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic act
);

    localparam int DEB_W = cnt_width(DEBOUNCE_N);
    localparam int REP_W = cnt_width(max_int(REP_DELAY, REP_PERIOD));

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_N);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REP_PERIOD);

    logic             sync_p0;
    logic             sync_p1;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       origin;
    logic [2:0]       origin_nxt;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_nxt;
    logic [DEB_W-1:0] deb_inc;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_nxt;
    logic [REP_W-1:0] rep_inc;
    logic [REP_W-1:0] rep_target;
    logic             level_nxt;
    logic             press_nxt;
    logic             rpt_nxt;

    assign deb_inc    = deb_cnt + DEB_W'(1);
    assign rep_inc    = rep_cnt + REP_W'(1);
    assign rep_target = (state == ST_DELAY) ? REP_FIRST : REP_NEXT;

    // Bring the asynchronous button level into the CLK domain
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Next-state logic; everything holds between ticks
    always_comb begin
        state_nxt  = state;
        origin_nxt = origin;
        deb_nxt    = deb_cnt;
        rep_nxt    = rep_cnt;
        level_nxt  = level;
        press_nxt  = 1'b0;
        rpt_nxt    = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE, ST_CONFIRM_PRESS: begin
                    // deb_cnt is zero in IDLE, so the first high tick counts as 1
                    if (sync_p1) begin
                        if (deb_inc == DEB_LAST) begin
                            state_nxt = ST_DELAY;
                            level_nxt = 1'b1;
                            press_nxt = 1'b1;
                            deb_nxt   = '0;
                            rep_nxt   = '0;
                        end else begin
                            state_nxt = ST_CONFIRM_PRESS;
                            deb_nxt   = deb_inc;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                        deb_nxt   = '0;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!sync_p1) begin
                        // First low tick counts toward release; repeat count is frozen
                        origin_nxt = state;
                        if (deb_inc == DEB_LAST) begin
                            state_nxt = ST_IDLE;
                            level_nxt = 1'b0;
                            deb_nxt   = '0;
                            rep_nxt   = '0;
                        end else begin
                            state_nxt = ST_CONFIRM_RELEASE;
                            deb_nxt   = deb_inc;
                        end
                    end else if (REP_EN) begin
                        if (rep_inc == rep_target) begin
                            state_nxt = ST_REPEAT;
                            rpt_nxt   = 1'b1;
                            rep_nxt   = '0;
                        end else begin
                            rep_nxt = rep_inc;
                        end
                    end
                end
                ST_CONFIRM_RELEASE: begin
                    if (!sync_p1) begin
                        if (deb_inc == DEB_LAST) begin
                            state_nxt = ST_IDLE;
                            level_nxt = 1'b0;
                            deb_nxt   = '0;
                            rep_nxt   = '0;
                        end else begin
                            deb_nxt = deb_inc;
                        end
                    end else begin
                        // Glitch: resume where we were, repeat phase kept
                        state_nxt = origin;
                        deb_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    deb_nxt   = '0;
                    rep_nxt   = '0;
                    level_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            origin  <= ST_IDLE;
            deb_cnt <= '0;
            rep_cnt <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
            act     <= 1'b0;
        end else begin
            state   <= state_nxt;
            origin  <= origin_nxt;
            deb_cnt <= deb_nxt;
            rep_cnt <= rep_nxt;
            level   <= level_nxt;
            press   <= press_nxt;
            act     <= press_nxt | rpt_nxt;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner: a shared sample prescaler plus one independent
// debounce / auto-repeat channel per button.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int                 SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int                 DEBOUNCE_N = DEF_DEBOUNCE_N,
    parameter int                 REP_DELAY  = DEF_REP_DELAY,
    parameter int                 REP_PERIOD = DEF_REP_PERIOD,
    parameter logic [NUM_BTN-1:0] REP_MASK   = DEF_REP_MASK
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] press,
    output logic [NUM_BTN-1:0] act,
    output logic               tick
);

    localparam int               DIV_W    = cnt_width(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Prescaler 0..SAMPLE_DIV-1; tick marks the last count of each period
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Gate with reset so tick is low during reset even when SAMPLE_DIV is 1
    assign tick = !reset && (div_cnt == DIV_LAST);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_N (DEBOUNCE_N),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD),
            .REP_EN     (REP_MASK[g])
        ) u_ch (
            .CLK     (CLK),
            .reset   (reset),
            .tick    (tick),
            .btn_raw (btn_raw[g]),
            .level   (level[g]),
            .press   (press[g]),
            .act     (act[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with fast timing (4 CLK per tick, 3-tick
// debounce, repeat after 5 ticks then every 2). Stimulus is applied one
// sample tick at a time; expected press/act events are queued up front
// and matched against every pulse the DUT produces.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int SDIV = 4;
    localparam int DEBN = 3;
    localparam int RDLY = 5;
    localparam int RPER = 2;

    logic       CLK = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] act;
    logic       tick;

    typedef struct {
        int         idx;
        logic [3:0] press;
        logic [3:0] act;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  n_cmp  = 0;
    int  n_err  = 0;
    int  tick_n = 0;

    always #5 CLK = ~CLK;

    button_conditioner #(
        .SAMPLE_DIV (SDIV),
        .DEBOUNCE_N (DEBN),
        .REP_DELAY  (RDLY),
        .REP_PERIOD (RPER),
        .REP_MASK   (4'b0011)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .btn_raw (btn_raw),
        .level   (level),
        .press   (press),
        .act     (act),
        .tick    (tick)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_ev(input int idx, input logic [3:0] p, input logic [3:0] a);
        ev_t e;
        e.idx   = idx;
        e.press = p;
        e.act   = a;
        sb.push_back(e);
    endtask

    // Wait for the falling edge inside the next tick cycle, bounded
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!tick && n < 4 * SDIV);
        if (!tick) chk_val("tick_timeout", {31'd0, tick}, 32'd1);
    endtask

    // Value applied here is what the next tick samples
    task automatic drive(input logic [3:0] v);
        btn_raw = v;
        wait_tick();
    endtask

    // Index of the tick cycle currently in progress
    always @(posedge CLK) begin
        if (tick) tick_n <= tick_n + 1;
    end

    // Every pulse must match the next queued event, attributed to the tick before it
    always @(negedge CLK) begin
        if ((press | act) != 4'b0000) begin
            if (sb.size() == 0) begin
                chk_val("spurious_pulse", {24'd0, press, act}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk_val("pulse_tick", tick_n - 1, mon_e.idx);
                chk_val("pulse_press", {28'd0, press}, {28'd0, mon_e.press});
                chk_val("pulse_act", {28'd0, act}, {28'd0, mon_e.act});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d events pending", sb.size());
        $fatal(1);
    end

    initial begin
        int         b;
        logic [3:0] m_left;
        logic [3:0] m_right;
        logic [3:0] m_throw;

        m_left  = 4'(1 << BTN_LEFT);
        m_right = 4'(1 << BTN_RIGHT);
        m_throw = 4'(1 << BTN_THROW);

        // Reset state
        reset   = 1'b1;
        btn_raw = 4'b0000;
        @(negedge CLK);
        @(negedge CLK);
        chk_val("rst_level", {28'd0, level}, 32'd0);
        chk_val("rst_press", {28'd0, press}, 32'd0);
        chk_val("rst_act", {28'd0, act}, 32'd0);
        chk_val("rst_tick", {31'd0, tick}, 32'd0);
        reset = 1'b0;
        wait_tick();

        // Clean press on the non-repeating throw button, 40 CLK high
        b = tick_n;
        push_ev(b + 3, m_throw, m_throw);
        for (int k = 1; k <= 16; k++) begin
            drive((k <= 10) ? m_throw : 4'b0000);
            if (k == 3)  chk_val("clean_lvl_t2", {28'd0, level}, 32'd0);
            if (k == 4)  chk_val("clean_lvl_t3", {28'd0, level}, {28'd0, m_throw});
            if (k == 13) chk_val("clean_lvl_t12", {28'd0, level}, {28'd0, m_throw});
            if (k == 14) chk_val("clean_lvl_t13", {28'd0, level}, 32'd0);
        end
        chk_val("clean_sb_empty", sb.size(), 32'd0);

        // Bounce on left: high 2, low 1, then high
        b = tick_n;
        push_ev(b + 6, m_left, m_left);
        for (int k = 1; k <= 12; k++) begin
            drive((k <= 2 || (k >= 4 && k <= 8)) ? m_left : 4'b0000);
            if (k == 6)  chk_val("bounce_lvl_t5", {28'd0, level}, 32'd0);
            if (k == 7)  chk_val("bounce_lvl_t6", {28'd0, level}, {28'd0, m_left});
            if (k == 11) chk_val("bounce_lvl_t10", {28'd0, level}, {28'd0, m_left});
            if (k == 12) chk_val("bounce_lvl_t11", {28'd0, level}, 32'd0);
        end
        chk_val("bounce_sb_empty", sb.size(), 32'd0);

        // Auto-repeat on right held for 20 ticks
        b = tick_n;
        push_ev(b + 3, m_right, m_right);
        for (int r = 3 + RDLY; r <= 20; r += RPER) push_ev(b + r, 4'b0000, m_right);
        for (int k = 1; k <= 24; k++) begin
            drive((k <= 20) ? m_right : 4'b0000);
            if (k == 22) chk_val("rep_lvl_t21", {28'd0, level}, {28'd0, m_right});
            if (k == 24) chk_val("rep_lvl_t23", {28'd0, level}, 32'd0);
        end
        chk_val("rep_sb_empty", sb.size(), 32'd0);

        // One-tick release glitch on left while repeating
        b = tick_n;
        push_ev(b + 3, m_left, m_left);
        push_ev(b + 8, 4'b0000, m_left);
        push_ev(b + 12, 4'b0000, m_left);
        push_ev(b + 14, 4'b0000, m_left);
        push_ev(b + 16, 4'b0000, m_left);
        for (int k = 1; k <= 21; k++) begin
            drive((k <= 16 && k != 10) ? m_left : 4'b0000);
            if (k == 11) chk_val("glitch_lvl_t10", {28'd0, level}, {28'd0, m_left});
            if (k == 12) chk_val("glitch_lvl_t11", {28'd0, level}, {28'd0, m_left});
            if (k == 19) chk_val("glitch_lvl_t18", {28'd0, level}, {28'd0, m_left});
            if (k == 20) chk_val("glitch_lvl_t19", {28'd0, level}, 32'd0);
        end
        chk_val("glitch_sb_empty", sb.size(), 32'd0);

        // Simultaneous press on left and right
        b = tick_n;
        push_ev(b + 3, m_left | m_right, m_left | m_right);
        for (int k = 1; k <= 8; k++) begin
            drive((k <= 4) ? (m_left | m_right) : 4'b0000);
            if (k == 4) chk_val("simul_lvl_t3", {28'd0, level}, {28'd0, m_left | m_right});
            if (k == 8) chk_val("simul_lvl_t7", {28'd0, level}, 32'd0);
        end
        chk_val("simul_sb_empty", sb.size(), 32'd0);

        // Reset while throw is two ticks into its press confirmation
        for (int k = 1; k <= 3; k++) drive(m_throw);
        reset = 1'b1;
        #1;
        chk_val("midrst_level", {28'd0, level}, 32'd0);
        chk_val("midrst_press", {28'd0, press}, 32'd0);
        chk_val("midrst_act", {28'd0, act}, 32'd0);
        chk_val("midrst_tick", {31'd0, tick}, 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        b = tick_n;
        push_ev(b + 2, m_throw, m_throw);
        for (int k = 1; k <= 9; k++) begin
            drive((k <= 5) ? m_throw : 4'b0000);
            if (k == 3) chk_val("midrst_lvl_t2", {28'd0, level}, 32'd0);
            if (k == 4) chk_val("midrst_lvl_t3", {28'd0, level}, {28'd0, m_throw});
            if (k == 9) chk_val("midrst_lvl_t8", {28'd0, level}, 32'd0);
        end
        chk_val("midrst_sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 50000, meaning CLK cycles per debounce sample tick (1 kHz at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_N, default 8, meaning consecutive disagreeing ticks needed to change a debounced level.
REQ-003 SHALL have parameter REP_DELAY, default 400, meaning ticks from the press pulse to the first repeat pulse.
REQ-004 SHALL have parameter REP_PERIOD, default 100, meaning ticks between later repeat pulses.
REQ-005 SHALL have parameter REP_MASK, default 4'b0011, meaning the channels that auto-repeat; bit0 left, bit1 right, bit2 throw, bit3 start.
REQ-006 SHALL have port CLK, input, 1 bit, the single system clock.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port btn_raw, input, 4 bits, asynchronous raw button levels (1 = pressed), indexed as in REQ-005.
REQ-009 SHALL have port level, output, 4 bits, debounced button state.
REQ-010 SHALL have port press, output, 4 bits, one-CLK pulse on each debounced rising edge.
REQ-011 SHALL have port act, output, 4 bits, one-CLK pulse equal to press OR repeat; the game logic consumes this.
REQ-012 SHALL have port tick, output, 1 bit, the shared sample strobe, exported for test.

Function
REQ-013 SHALL pass each btn_raw bit through a 2-flop synchronizer; all logic below uses only the synchronized value.
REQ-014 SHALL count a prescaler 0..SAMPLE_DIV-1 with wrap, and drive tick high for exactly the one CLK whose count is SAMPLE_DIV-1.
REQ-015 SHALL give each channel an FSM with states IDLE, CONFIRM_PRESS, DELAY, REPEAT, CONFIRM_RELEASE; the FSM advances only on tick.
REQ-016 IDLE: synced=1 -> CONFIRM_PRESS with the debounce counter set to 1.
REQ-017 CONFIRM_PRESS: synced=1 increments the counter, and reaching DEBOUNCE_N -> DELAY with level=1 and press=1 for that CLK; synced=0 -> IDLE with the counter cleared and no pulse.
REQ-018 DELAY/REPEAT: the repeat counter increments per tick; synced=0 -> CONFIRM_RELEASE, storing the origin state.
REQ-019 DELAY: for a REP_MASK channel, the counter reaching REP_DELAY -> REPEAT with a repeat pulse and the counter cleared; non-masked channels stay in DELAY indefinitely.
REQ-020 REPEAT: the counter reaching REP_PERIOD SHALL produce a repeat pulse and clear the counter.
REQ-021 CONFIRM_RELEASE: synced=0 for DEBOUNCE_N ticks -> IDLE with level=0 and no pulse; synced=1 earlier -> return to the origin state with the repeat counter unchanged and the debounce counter cleared.
REQ-022 No repeat pulse SHALL occur while in CONFIRM_RELEASE.
REQ-023 press and act SHALL each be high for exactly one CLK per event; the DEBOUNCE_N-th tick asserts them at the first CLK edge after the tick.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL pulse in the same CLK.
REQ-025 Counters SHALL saturate-free wrap only by the explicit clears above; widths SHALL be $clog2(parameter)+1.

Reset
REQ-026 reset SHALL asynchronously force: synchronizers 0, prescaler 0, all FSMs IDLE, all counters 0, level/press/act/tick = 0.
REQ-027 reset asserted mid-press SHALL emit no pulse; after release, a held button SHALL need a full DEBOUNCE_N confirmation.

Structure
REQ-028 Button index constants, FSM state encoding, and default timing values SHALL live in shared package btn_pkg.
REQ-029 Per-channel synchronizer, FSM and counters SHALL be sub-module btn_channel, instantiated 4 times; the prescaler stays in the top.

Verification (SAMPLE_DIV=4, DEBOUNCE_N=3, REP_DELAY=5, REP_PERIOD=2)
REQ-030 Clean press: btn_raw[2] high for 40 CLK -> level[2] rises after the 3rd tick; exactly one press[2]/act[2] pulse; no repeat, since bit2 is not masked.
REQ-031 Bounce: btn_raw[0] high for 2 ticks, low 1 tick, then high -> no pulse until 3 consecutive high ticks; then exactly one press[0].
REQ-032 Auto-repeat: hold btn_raw[1] for 20 ticks -> press at tick 3, act repeats at ticks 8, 10, 12, ...; press pulses only once.
REQ-033 Release glitch: during REPEAT drop btn_raw[0] for 1 tick -> level stays 1; repeat cadence resumes with no extra pulse; a full 3-tick low -> level 0.
REQ-034 Simultaneous: btn_raw=4'b0011 together -> press[0] and press[1] in the same CLK.
REQ-035 Reset mid-CONFIRM_PRESS: assert reset for 1 CLK -> all outputs 0 immediately; no press until 3 new ticks of high.
